// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage -- memory stage of the five-stage MIPS pipeline
// ============================================================================
// Owns the EX/MEM latch. Each instruction from execute is captured here, and
// any load or store it carries is issued to the data cache. While the cache
// has not answered (dhit low), the upstream stages are frozen through
// mem_stall. The stage presents all write-back candidates (ALU result, load
// data, LUI value, nPC) to the write-back mux. When a halt instruction sits
// in the latch with no access outstanding, a sticky halt is raised.
//
// Optional feature (compile-time macro):
//   MEM_ALIGN_CHK_EN  - word-alignment check on loads and stores. A
//                       misaligned access is latched without its
//                       memory/register side effects and raises a sticky
//                       misalign flag. When the macro is undefined,
//                       misalign is tied low.
//
// Ports:
//   CLK, RST                   rising-edge clock, synchronous active-high reset
//   exmen                      EX/MEM latch enable from the hazard unit
//   flush                      load a bubble instead of execute's outputs
//   nPC_in, ALUOut_in,
//   dmemstore_in, lui_in       32-bit values from execute
//   dREN_in, dWEN_in,
//   regWr_in, halt_in          control bits from execute
//   regSel_in [2:0]            write-back source select
//   regDst_in [4:0]            destination register
//   dhit                       cache completion for the current request
//   dmemload [31:0]            cache read data
//   dmemREN, dmemWEN           cache request strobes
//   dmemaddr, dmemstore        cache address and write data
//   mem_stall                  freezes the upstream stages
//   regWr_wb                   register-file write strobe
//   regSel_wb, regDst_wb       latched write-back select and destination
//   ALUOut_wb, load_wb,
//   lui_wb, nPC_wb             write-back candidates
//   halt                       sticky CPU halt
//   misalign                   sticky alignment error (0 without the macro)
// ============================================================================
module mem_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        exmen,
    input  logic        flush,
    input  logic [31:0] nPC_in,
    input  logic [31:0] ALUOut_in,
    input  logic [31:0] dmemstore_in,
    input  logic [31:0] lui_in,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic        regWr_in,
    input  logic        halt_in,
    input  logic [2:0]  regSel_in,
    input  logic [4:0]  regDst_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        regWr_wb,
    output logic [2:0]  regSel_wb,
    output logic [4:0]  regDst_wb,
    output logic [31:0] ALUOut_wb,
    output logic [31:0] load_wb,
    output logic [31:0] lui_wb,
    output logic [31:0] nPC_wb,
    output logic        halt,
    output logic        misalign
);

    // ------------------------------------------------------------------------
    // Access FSM state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no request outstanding
        ST_WAIT = 2'd1,   // request asserted to the cache
        ST_DONE = 2'd2    // access complete, waiting for the latch to advance
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Index of each 32-bit word field inside the wide part of the latch.
    localparam int NUM_WORDS = 4;
    localparam int W_NPC     = 0;
    localparam int W_ALU     = 1;
    localparam int W_STORE   = 2;
    localparam int W_LUI     = 3;

    // ------------------------------------------------------------------------
    // EX/MEM latch storage
    // ------------------------------------------------------------------------
    logic [31:0] word_in  [NUM_WORDS];
    logic [31:0] word_reg [NUM_WORDS];

    logic        dren_reg;
    logic        dwen_reg;
    logic        regwr_reg;
    logic        halt_field_reg;
    logic [2:0]  regsel_reg;
    logic [4:0]  regdst_reg;

    logic [31:0] ld_reg;
    logic        halt_reg;

    // ------------------------------------------------------------------------
    // Latch control
    // ------------------------------------------------------------------------
    // The stall and the sticky halt take precedence over flush and exmen, so
    // an instruction stuck waiting on the cache can never be overwritten.
    logic latch_hold;
    logic latch_bubble;
    logic latch_load;
    logic latch_adv;
    logic mem_in;
    logic misalign_in;
    logic mem_accept;

    assign latch_hold   = mem_stall | halt_reg;
    assign latch_bubble = ~latch_hold & flush;
    assign latch_load   = ~latch_hold & ~flush & exmen;
    assign latch_adv    = latch_bubble | latch_load;

    assign mem_in       = dREN_in | dWEN_in;

`ifdef MEM_ALIGN_CHK_EN
    // Any load or store whose address is not word-aligned is rejected.
    assign misalign_in  = mem_in & (ALUOut_in[1:0] != 2'b00);
`else
    assign misalign_in  = 1'b0;
`endif

    // A new access enters WAIT only if it is actually latched and legal.
    assign mem_accept   = latch_load & mem_in & ~misalign_in;

    assign word_in[W_NPC]   = nPC_in;
    assign word_in[W_ALU]   = ALUOut_in;
    assign word_in[W_STORE] = dmemstore_in;
    assign word_in[W_LUI]   = lui_in;

    // Wide data fields share identical clear / bubble / load / hold behaviour.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_latch
            always_ff @(posedge CLK) begin
                if (RST) begin
                    word_reg[gi] <= '0;
                end else if (latch_bubble) begin
                    word_reg[gi] <= '0;
                end else if (latch_load) begin
                    word_reg[gi] <= word_in[gi];
                end
            end
        end
    endgenerate

    // Control fields. A rejected misaligned access keeps its data fields but
    // loses every side effect (memory strobes and the register write).
    always_ff @(posedge CLK) begin
        if (RST) begin
            dren_reg       <= 1'b0;
            dwen_reg       <= 1'b0;
            regwr_reg      <= 1'b0;
            halt_field_reg <= 1'b0;
            regsel_reg     <= '0;
            regdst_reg     <= '0;
        end else if (latch_bubble) begin
            dren_reg       <= 1'b0;
            dwen_reg       <= 1'b0;
            regwr_reg      <= 1'b0;
            halt_field_reg <= 1'b0;
            regsel_reg     <= '0;
            regdst_reg     <= '0;
        end else if (latch_load) begin
            dren_reg       <= dREN_in  & ~misalign_in;
            dwen_reg       <= dWEN_in  & ~misalign_in;
            regwr_reg      <= regWr_in & ~misalign_in;
            halt_field_reg <= halt_in;
            regsel_reg     <= regSel_in;
            regdst_reg     <= regDst_in;
        end
    end

    // ------------------------------------------------------------------------
    // Access FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Access FSM: next state
    // ------------------------------------------------------------------------
    // Whenever the latch advances, the new occupant decides the state: a
    // memory access starts a fresh WAIT, anything else (including a bubble)
    // returns to IDLE. This also covers the dhit cycle, where the latch may
    // advance in the same cycle the access completes.
    always_comb begin
        state_next = state_reg;
        if (latch_adv) begin
            state_next = mem_accept ? ST_WAIT : ST_IDLE;
        end else if ((state_reg == ST_WAIT) && dhit) begin
            state_next = ST_DONE;
        end
    end

    // ------------------------------------------------------------------------
    // Access FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        if (state_reg == ST_WAIT) begin
            dmemREN   = dren_reg & ~halt_reg;
            dmemWEN   = dwen_reg & ~halt_reg;
            mem_stall = ~dhit;
        end
    end

    // ------------------------------------------------------------------------
    // Load data capture
    // ------------------------------------------------------------------------
    // The completing cycle bypasses dmemload straight to load_wb; the copy in
    // ld_reg keeps the value valid while the latch waits to advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_reg <= '0;
        end else if ((state_reg == ST_WAIT) && dhit) begin
            ld_reg <= dmemload;
        end
    end

    assign load_wb = (state_reg == ST_WAIT) ? dmemload : ld_reg;

    // ------------------------------------------------------------------------
    // Sticky halt
    // ------------------------------------------------------------------------
    // The halt waits until no access is outstanding, so a store ahead of the
    // halt always reaches the cache first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halt_reg <= 1'b0;
        end else if (halt_field_reg && (state_reg != ST_WAIT)) begin
            halt_reg <= 1'b1;
        end
    end

    assign halt = halt_reg;

    // ------------------------------------------------------------------------
    // Alignment error flag
    // ------------------------------------------------------------------------
`ifdef MEM_ALIGN_CHK_EN
    logic misalign_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_reg <= 1'b0;
        end else if (latch_load && misalign_in) begin
            misalign_reg <= 1'b1;
        end
    end

    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Cache request data and write-back outputs
    // ------------------------------------------------------------------------
    assign dmemaddr  = word_reg[W_ALU];
    assign dmemstore = word_reg[W_STORE];

    // Suppressing the strobe while stalled gives one effective write per
    // instruction even though the latch is held across the stall.
    assign regWr_wb  = regwr_reg & ~mem_stall;
    assign regSel_wb = regsel_reg;
    assign regDst_wb = regdst_reg;
    assign ALUOut_wb = word_reg[W_ALU];
    assign lui_wb    = word_reg[W_LUI];
    assign nPC_wb    = word_reg[W_NPC];

endmodule

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage -- directed bench for mem_stage
// ============================================================================
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later,
// well away from the active edge. Expected values are hand-computed.
// ============================================================================
module tb_mem_stage;

    logic        CLK;
    logic        RST;
    logic        exmen;
    logic        flush;
    logic [31:0] nPC_in;
    logic [31:0] ALUOut_in;
    logic [31:0] dmemstore_in;
    logic [31:0] lui_in;
    logic        dREN_in;
    logic        dWEN_in;
    logic        regWr_in;
    logic        halt_in;
    logic [2:0]  regSel_in;
    logic [4:0]  regDst_in;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic        regWr_wb;
    logic [2:0]  regSel_wb;
    logic [4:0]  regDst_wb;
    logic [31:0] ALUOut_wb;
    logic [31:0] load_wb;
    logic [31:0] lui_wb;
    logic [31:0] nPC_wb;
    logic        halt;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .exmen        (exmen),
        .flush        (flush),
        .nPC_in       (nPC_in),
        .ALUOut_in    (ALUOut_in),
        .dmemstore_in (dmemstore_in),
        .lui_in       (lui_in),
        .dREN_in      (dREN_in),
        .dWEN_in      (dWEN_in),
        .regWr_in     (regWr_in),
        .halt_in      (halt_in),
        .regSel_in    (regSel_in),
        .regDst_in    (regDst_in),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .mem_stall    (mem_stall),
        .regWr_wb     (regWr_wb),
        .regSel_wb    (regSel_wb),
        .regDst_wb    (regDst_wb),
        .ALUOut_wb    (ALUOut_wb),
        .load_wb      (load_wb),
        .lui_wb       (lui_wb),
        .nPC_wb       (nPC_wb),
        .halt         (halt),
        .misalign     (misalign)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_nop();
        nPC_in       = '0;
        ALUOut_in    = '0;
        dmemstore_in = '0;
        lui_in       = '0;
        dREN_in      = 1'b0;
        dWEN_in      = 1'b0;
        regWr_in     = 1'b0;
        halt_in      = 1'b0;
        regSel_in    = '0;
        regDst_in    = '0;
    endtask

    initial begin
        int ren_cnt;
        int stall_cnt;
        int wr_cnt;

        RST      = 1'b1;
        exmen    = 1'b0;
        flush    = 1'b0;
        dhit     = 1'b0;
        dmemload = '0;
        set_nop();
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_regWr",   regWr_wb,  0);
        chk("rst_ren",     dmemREN,   0);
        chk("rst_wen",     dmemWEN,   0);
        chk("rst_stall",   mem_stall, 0);
        chk("rst_halt",    halt,      0);
        chk("rst_load",    load_wb,   0);
        chk("rst_alu",     ALUOut_wb, 0);
        chk("rst_npc",     nPC_wb,    0);
        chk("rst_lui",     lui_wb,    0);
        chk("rst_dst",     regDst_wb, 0);
        chk("rst_misal",   misalign,  0);
        $display("reset: outputs checked");

        // ---------------- bubble ----------------
        RST   = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("bub_regWr", regWr_wb,  0);
        chk("bub_stall", mem_stall, 0);
        chk("bub_addr",  dmemaddr,  0);
        $display("bubble: outputs checked");

        // ---------------- non-memory instruction ----------------
        regWr_in  = 1'b1;
        ALUOut_in = 32'h0000_0055;
        regDst_in = 5'd2;
        exmen     = 1'b1;
        tick();
        set_nop();
        exmen = 1'b0;
        #1;
        chk("alu_out",   ALUOut_wb, 32'h0000_0055);
        chk("alu_regWr", regWr_wb,  1);
        chk("alu_dst",   regDst_wb, 2);
        chk("alu_ren",   dmemREN,   0);
        chk("alu_stall", mem_stall, 0);
        $display("alu: ALUOut_wb=0x%08h", ALUOut_wb);

        // ---------------- lw with dhit on the third cycle ----------------
        dREN_in   = 1'b1;
        regWr_in  = 1'b1;
        ALUOut_in = 32'h0000_0100;
        regDst_in = 5'd5;
        regSel_in = 3'd1;
        nPC_in    = 32'h0000_0044;
        lui_in    = 32'hABCD_0000;
        exmen     = 1'b1;
        tick();
        set_nop();
        exmen     = 1'b0;
        ren_cnt   = 0;
        stall_cnt = 0;
        wr_cnt    = 0;
        for (int i = 0; i < 3; i++) begin
            dhit     = (i == 2);
            dmemload = (i == 2) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            exmen    = (i == 2);   // advance with a nop in the completing cycle
            #1;
            chk("lw_ren",   dmemREN,   1);
            chk("lw_stall", mem_stall, (i < 2) ? 1 : 0);
            chk("lw_addr",  dmemaddr,  32'h0000_0100);
            chk("lw_regWr", regWr_wb,  (i == 2) ? 1 : 0);
            if (i == 0) begin
                chk("lw_lui", lui_wb,    32'hABCD_0000);
                chk("lw_npc", nPC_wb,    32'h0000_0044);
                chk("lw_sel", regSel_wb, 1);
                chk("lw_dst", regDst_wb, 5);
            end
            if (i == 2) chk("lw_load", load_wb, 32'hDEAD_BEEF);
            if (dmemREN)   ren_cnt++;
            if (mem_stall) stall_cnt++;
            if (regWr_wb)  wr_cnt++;
            tick();
        end
        dhit  = 1'b0;
        exmen = 1'b0;
        #1;
        if (dmemREN)  ren_cnt++;
        if (regWr_wb) wr_cnt++;
        chk("lw_ren_cycles",   ren_cnt,   3);
        chk("lw_stall_cycles", stall_cnt, 2);
        chk("lw_wr_pulses",    wr_cnt,    1);
        chk("lw_load_held",    load_wb,   32'hDEAD_BEEF);
        $display("lw: ren=%0d stall=%0d wr=%0d load_wb=0x%08h", ren_cnt, stall_cnt, wr_cnt, load_wb);

        // ---------------- sw with dhit in the first cycle ----------------
        dWEN_in      = 1'b1;
        ALUOut_in    = 32'h0000_0040;
        dmemstore_in = 32'h1234_5678;
        exmen        = 1'b1;
        tick();
        set_nop();
        exmen = 1'b1;
        dhit  = 1'b1;
        #1;
        chk("sw_wen",   dmemWEN,   1);
        chk("sw_data",  dmemstore, 32'h1234_5678);
        chk("sw_addr",  dmemaddr,  32'h0000_0040);
        chk("sw_stall", mem_stall, 0);
        chk("sw_ren",   dmemREN,   0);
        chk("sw_regWr", regWr_wb,  0);
        tick();
        dhit  = 1'b0;
        exmen = 1'b0;
        #1;
        chk("sw_wen_off",   dmemWEN,   0);
        chk("sw_stall_off", mem_stall, 0);
        $display("sw: store to 0x00000040 checked");

        // ---------------- flush/exmen during a stalled load ----------------
        dREN_in   = 1'b1;
        regWr_in  = 1'b1;
        ALUOut_in = 32'h0000_0200;
        regDst_in = 5'd7;
        exmen     = 1'b1;
        tick();
        set_nop();
        regWr_in  = 1'b1;
        ALUOut_in = 32'h0000_0999;
        regDst_in = 5'd9;
        flush     = 1'b1;
        exmen     = 1'b1;
        dhit      = 1'b0;
        #1;
        chk("fl_stall", mem_stall, 1);
        tick();
        chk("fl_addr_held",  dmemaddr,  32'h0000_0200);
        chk("fl_dst_held",   regDst_wb, 7);
        chk("fl_ren_held",   dmemREN,   1);
        chk("fl_stall_held", mem_stall, 1);
        flush    = 1'b0;
        exmen    = 1'b0;
        set_nop();
        dhit     = 1'b1;
        dmemload = 32'hCAFE_F00D;
        #1;
        chk("fl_load",  load_wb,   32'hCAFE_F00D);
        chk("fl_regWr", regWr_wb,  1);
        chk("fl_nostall", mem_stall, 0);
        tick();
        dhit     = 1'b0;
        dmemload = '0;
        flush    = 1'b1;
        #1;
        chk("fl_done_stall", mem_stall, 0);
        chk("fl_done_load",  load_wb,   32'hCAFE_F00D);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_bub_regWr", regWr_wb,  0);
        chk("fl_bub_dst",   regDst_wb, 0);
        chk("fl_bub_ren",   dmemREN,   0);
        $display("flush: hold during stall and bubble afterwards checked");

        // ---------------- dhit outside WAIT ----------------
        dhit     = 1'b1;
        dmemload = 32'h1111_1111;
        #1;
        chk("idle_dhit_load", load_wb, 32'hCAFE_F00D);
        tick();
        dhit = 1'b0;
        #1;
        chk("idle_dhit_kept", load_wb, 32'hCAFE_F00D);
        $display("idle dhit: ignored");

        // ---------------- RST during WAIT ----------------
        dREN_in   = 1'b1;
        ALUOut_in = 32'h0000_0400;
        exmen     = 1'b1;
        tick();
        set_nop();
        exmen = 1'b0;
        #1;
        chk("rw_ren", dmemREN, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rw_ren_drop", dmemREN,   0);
        chk("rw_stall",    mem_stall, 0);
        chk("rw_load",     load_wb,   0);
        chk("rw_addr",     dmemaddr,  0);
        $display("reset during wait: request dropped");

`ifdef MEM_ALIGN_CHK_EN
        // ---------------- misaligned lw ----------------
        dREN_in   = 1'b1;
        regWr_in  = 1'b1;
        ALUOut_in = 32'h0000_0102;
        regDst_in = 5'd4;
        exmen     = 1'b1;
        tick();
        set_nop();
        exmen = 1'b0;
        #1;
        chk("mis_ren",   dmemREN,   0);
        chk("mis_flag",  misalign,  1);
        chk("mis_regWr", regWr_wb,  0);
        chk("mis_stall", mem_stall, 0);
        tick();
        chk("mis_sticky", misalign, 1);
        $display("misaligned lw: rejected");
`else
        chk("mis_tied", misalign, 0);
`endif

        // ---------------- halt behind a pending sw ----------------
        dWEN_in      = 1'b1;
        ALUOut_in    = 32'h0000_0080;
        dmemstore_in = 32'h0000_0077;
        exmen        = 1'b1;
        tick();
        set_nop();
        halt_in = 1'b1;
        exmen   = 1'b1;
        dhit    = 1'b0;
        #1;
        chk("h_wait1_halt",  halt,      0);
        chk("h_wait1_stall", mem_stall, 1);
        tick();
        chk("h_wait2_halt", halt,    0);
        chk("h_wait2_wen",  dmemWEN, 1);
        dhit = 1'b1;
        #1;
        chk("h_hit_halt",  halt,      0);
        chk("h_hit_stall", mem_stall, 0);
        tick();
        dhit    = 1'b0;
        halt_in = 1'b0;
        exmen   = 1'b0;
        #1;
        chk("h_latched_halt", halt,    0);
        chk("h_latched_wen",  dmemWEN, 0);
        tick();
        chk("h_set", halt, 1);
        for (int i = 0; i < 3; i++) begin
            dREN_in   = 1'b1;
            regWr_in  = 1'b1;
            ALUOut_in = 32'h0000_0300;
            regDst_in = 5'd3;
            exmen     = 1'b1;
            tick();
            chk("h_sticky", halt,      1);
            chk("h_noreq",  dmemREN,   0);
            chk("h_dst",    regDst_wb, 0);
            chk("h_stall",  mem_stall, 0);
        end
        set_nop();
        exmen = 1'b0;
        $display("halt: raised after sw completion and held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
